// File: rtl/ram_pkg.sv
// ram_pkg: definitions shared by the RAM access arbiter, its interface and
// its arbitration sub-module.
//   - state_t       : access sequencer states (IDLE, WR, RD_ADDR, RD_DATA)
//   - PORT0/PORT1   : client port indices, also the bit positions in grant vectors
//   - RAM_*         : default geometry of single_port_ram
//   - addr_in_range : true when an address maps onto an implemented RAM word
package ram_pkg;

  localparam int RAM_ADDRWIDTH = 4;
  localparam int RAM_DATAWIDTH = 8;
  localparam int RAM_SIZE      = 16;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned size);
    return (addr < size);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: client handshakes and RAM control bundle for
// ram_port_arbiter. The bidirectional RAM data bus is a plain inout on the
// arbiter and is not part of this bundle.
//   client side : req0/1, req_we0/1, req_addr0/1, req_wdata0/1 (to arbiter)
//                 gnt0/1, rvalid0/1, rdata0/1                   (from arbiter)
//   RAM side    : addr, cs, we, oe                              (from arbiter)
// Modports: master = client/RAM environment, slave = the arbiter.
interface ram_port_arbiter_if
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH = RAM_ADDRWIDTH,
  parameter int DATAWIDTH = RAM_DATAWIDTH
);

  logic                 req0;
  logic                 req1;
  logic                 req_we0;
  logic                 req_we1;
  logic [ADDRWIDTH-1:0] req_addr0;
  logic [ADDRWIDTH-1:0] req_addr1;
  logic [DATAWIDTH-1:0] req_wdata0;
  logic [DATAWIDTH-1:0] req_wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rvalid0;
  logic                 rvalid1;
  logic [DATAWIDTH-1:0] rdata0;
  logic [DATAWIDTH-1:0] rdata1;
  logic [ADDRWIDTH-1:0] addr;
  logic                 cs;
  logic                 we;
  logic                 oe;

  modport master (
    output req0, req1, req_we0, req_we1, req_addr0, req_addr1,
           req_wdata0, req_wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           addr, cs, we, oe
  );

  modport slave (
    input  req0, req1, req_we0, req_we1, req_addr0, req_addr1,
           req_wdata0, req_wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           addr, cs, we, oe
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way request arbiter producing a one-hot grant.
//   clk, rst  : clock and synchronous active-high reset (pointer only)
//   i_req     : request vector, bit PORT0 / PORT1
//   i_advance : a grant was accepted this cycle; moves the pointer
//   o_gnt     : one-hot grant (all zero when nothing is requested)
// Build option RAM_ARB_RR_EN: when defined, simultaneous requests are
// resolved round-robin; otherwise port 0 has fixed priority and no pointer
// exists.
module rr_arbiter2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

`ifdef RAM_ARB_RR_EN
  // Port granted most recently. Reset as if port 1 had just won so that
  // port 0 takes the first contested grant.
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_advance) begin
      r_last <= o_gnt[PORT1];
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[PORT0] && i_req[PORT1]) begin
      o_gnt[PORT0] = r_last;
      o_gnt[PORT1] = ~r_last;
    end else begin
      o_gnt = i_req;
    end
  end
`else
  // Fixed priority needs neither the clock nor the advance strobe.
  logic w_unused;
  assign w_unused = ^{clk, rst, i_advance};

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[PORT0]) begin
      o_gnt[PORT0] = 1'b1;
    end else if (i_req[PORT1]) begin
      o_gnt[PORT1] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single_port_ram port between two clients and
// sequences each access (write: 1 cycle, read: address + data cycles).
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_port_arbiter_if.slave (client handshakes, RAM addr/cs/we/oe)
//   data     : bidirectional RAM data bus, driven here only during writes
// Out-of-range addresses (>= SIZE) walk the normal sequence with cs held low;
// reads of them return zero.
// Build option RAM_ARB_RR_EN selects round-robin arbitration (see rr_arbiter2).
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH = RAM_ADDRWIDTH,
  parameter int DATAWIDTH = RAM_DATAWIDTH,
  parameter int SIZE      = RAM_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    bus,
  inout  wire  [DATAWIDTH-1:0] data
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_owner;
  logic [ADDRWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic                 r_in_range;
  logic [DATAWIDTH-1:0] r_rdata0;
  logic [DATAWIDTH-1:0] r_rdata1;
  logic                 r_rvalid0;
  logic                 r_rvalid1;

  logic [1:0]           w_arb_gnt;
  logic [1:0]           w_gnt;
  logic                 w_take;
  logic                 w_sel_we;
  logic [ADDRWIDTH-1:0] w_sel_addr;
  logic [DATAWIDTH-1:0] w_sel_wdata;
  logic [DATAWIDTH-1:0] w_capture;
  logic                 w_cs;
  logic                 w_we;
  logic                 w_oe;
  logic                 w_drive;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     ({bus.req1, bus.req0}),
    .i_advance (w_take),
    .o_gnt     (w_arb_gnt)
  );

  // Grants are only offered from IDLE and are suppressed during reset.
  assign w_gnt  = ((r_state == IDLE) && !rst) ? w_arb_gnt : 2'b00;
  assign w_take = |w_gnt;

  assign w_sel_we    = w_gnt[PORT1] ? bus.req_we1    : bus.req_we0;
  assign w_sel_addr  = w_gnt[PORT1] ? bus.req_addr1  : bus.req_addr0;
  assign w_sel_wdata = w_gnt[PORT1] ? bus.req_wdata1 : bus.req_wdata0;

  // Unmapped words read back as zero; the RAM is not selected for them.
  assign w_capture = r_in_range ? data : '0;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_take) w_next_state = w_sel_we ? WR : RD_ADDR;
      WR:      w_next_state = IDLE;
      RD_ADDR: w_next_state = RD_DATA;
      RD_DATA: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // RAM controls depend only on the state register and latched fields.
  always_comb begin
    w_cs    = 1'b0;
    w_we    = 1'b0;
    w_oe    = 1'b0;
    w_drive = 1'b0;
    unique case (r_state)
      WR: begin
        w_cs    = r_in_range;
        w_we    = 1'b1;
        w_drive = 1'b1;
      end
      RD_ADDR, RD_DATA: begin
        w_cs = r_in_range;
        w_oe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_take) begin
        r_owner    <= w_gnt[PORT1];
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        r_in_range <= addr_in_range(32'(w_sel_addr), SIZE);
      end
      if (r_state == RD_DATA) begin
        if (r_owner) begin
          r_rdata1  <= w_capture;
          r_rvalid1 <= 1'b1;
        end else begin
          r_rdata0  <= w_capture;
          r_rvalid0 <= 1'b1;
        end
      end
    end
  end

  assign data = w_drive ? r_wdata : {DATAWIDTH{1'bz}};

  assign bus.gnt0    = w_gnt[PORT0];
  assign bus.gnt1    = w_gnt[PORT1];
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign bus.addr    = r_addr;
  assign bus.cs      = w_cs;
  assign bus.we      = w_we;
  assign bus.oe      = w_oe;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int SIZE = 12;
`ifdef RAM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire [DW-1:0] data;
  ram_port_arbiter_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  ram_port_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SIZE(SIZE)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  // Behavioural single_port_ram: write on cs&we, address sampled in the
  // first read cycle, data driven in the second.
  logic          ram_init = 1'b1;
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_q;
  logic          ram_drv;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(8'hE0 + i);
      ram_drv <= 1'b0;
      ram_q   <= '0;
    end else begin
      if (bus.cs && bus.we) ram_mem[bus.addr] <= data;
      ram_drv <= bus.cs && bus.oe && !bus.we;
      if (bus.cs && bus.oe && !bus.we) ram_q <= ram_mem[bus.addr];
    end
  end
  assign data = (ram_drv && bus.cs && bus.oe && !bus.we) ? ram_q : {DW{1'bz}};

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
  } rd_exp_t;

  int      checks = 0;
  int      errors = 0;
  vec_t    q0[$];
  vec_t    q1[$];
  rd_exp_t sb[$];
  int      gseq[$];

  logic          act      = 1'b0;
  logic          act_we   = 1'b0;
  logic          act_inr  = 1'b0;
  logic          act_port = 1'b0;
  logic [AW-1:0] act_addr = '0;
  int            age      = 0;
  logic          rr_last  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic drive_req();
    bus.req0 = (q0.size() > 0);
    bus.req1 = (q1.size() > 0);
    if (q0.size() > 0) begin
      bus.req_we0 = q0[0].we; bus.req_addr0 = q0[0].addr; bus.req_wdata0 = q0[0].wdata;
    end
    if (q1.size() > 0) begin
      bus.req_we1 = q1[0].we; bus.req_addr1 = q1[0].addr; bus.req_wdata1 = q1[0].wdata;
    end
  endtask

  // Called mid-cycle: compares DUT outputs with the expected transaction timing.
  task automatic observe();
    logic    idle;
    logic    e_cs, e_we, e_oe, e_rv0, e_rv1;
    logic [1:0] e_gnt;
    logic    win;
    vec_t    v;
    rd_exp_t e;
    e_cs = 0; e_we = 0; e_oe = 0; e_rv0 = 0; e_rv1 = 0; e_gnt = 2'b00; win = 0;
    idle = !act || (act_we && age >= 2) || (!act_we && age >= 3);
    if (act && !idle) begin
      e_cs = act_inr; e_we = act_we; e_oe = !act_we;
      chk("addr", bus.addr, act_addr);
    end
    if (act && !act_we && age == 3) begin
      if (act_port) e_rv1 = 1; else e_rv0 = 1;
    end
    chk("cs", bus.cs, e_cs);
    chk("we", bus.we, e_we);
    chk("oe", bus.oe, e_oe);
    chk("oe_we_excl", bus.oe & bus.we, 0);
    chk("rvalid0", bus.rvalid0, e_rv0);
    chk("rvalid1", bus.rvalid1, e_rv1);
    if (bus.rvalid0 || bus.rvalid1) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", {bus.rvalid1, bus.rvalid0}, 0);
      end else begin
        e = sb.pop_front();
        chk("rv_owner", {bus.rvalid1, bus.rvalid0}, e.port ? 2'b10 : 2'b01);
        chk("rdata", e.port ? bus.rdata1 : bus.rdata0, e.rdata);
      end
    end
    if (bus.gnt0 || bus.gnt1) gseq.push_back(bus.gnt1 ? 1 : 0);
    if (idle) begin
      act = 0;
      if (q0.size() > 0 && q1.size() > 0) win = RR_MODE ? !rr_last : 1'b0;
      else win = (q1.size() > 0);
      if (q0.size() > 0 || q1.size() > 0) e_gnt = win ? 2'b10 : 2'b01;
    end
    chk("gnt", {bus.gnt1, bus.gnt0}, e_gnt);
    if (e_gnt != 2'b00) begin
      if (win) v = q1.pop_front(); else v = q0.pop_front();
      rr_last = win;
      act = 1; age = 0; act_we = v.we; act_addr = v.addr;
      act_inr = (v.addr < SIZE); act_port = win;
      if (!v.we) sb.push_back('{win, v.exp_rdata});
    end
    if (act) age++;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act) && n < budget) begin
      @(posedge clk); #1;
      drive_req();
      @(negedge clk);
      observe();
      n++;
    end
    if (n >= budget) chk("run_budget", n, 0);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; bus.req0 = 0; bus.req1 = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    act = 0; age = 0; rr_last = 1; sb.delete(); q0.delete(); q1.delete();
  endtask

  task automatic load(input vec_t v);
    if (v.port) q1.push_back(v); else q0.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tbl [10];
    logic [DW-1:0] fill [16];
    vec_t          v;
    int            bad;

    tbl[0] = '{1'b0, 1'b1, 4'd3,  8'hA5, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 4'd1,  8'h11, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 4'd2,  8'h22, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 4'd1,  8'h00, 8'h11};
    tbl[5] = '{1'b1, 1'b0, 4'd2,  8'h00, 8'h22};
    tbl[6] = '{1'b0, 1'b1, 4'd13, 8'h77, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 4'd13, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 4'd12, 8'h00, 8'h00};
    tbl[9] = '{1'b0, 1'b0, 4'd13, 8'h00, 8'h00};

    bus.req0 = 1; bus.req1 = 1; bus.req_we0 = 0; bus.req_we1 = 0;
    bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    rst = 1;
    @(posedge clk); #1; ram_init = 0;
    @(negedge clk);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("rst_ctrl", {bus.cs, bus.we, bus.oe}, 0);
    chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_rdata", {bus.rdata1, bus.rdata0}, 0);
    do_reset();

    // write then read, single client
    for (int i = 0; i < 2; i++) load(tbl[i]);
    run(40);

    // simultaneous requests after reset
    do_reset();
    gseq.delete();
    for (int i = 2; i < 6; i++) load(tbl[i]);
    run(60);
    chk("sim_first", gseq[0], 0);
    chk("sim_second", gseq[1], RR_MODE ? 1 : 0);

    // out-of-range accesses
    for (int i = 6; i < 10; i++) load(tbl[i]);
    run(60);
    chk("oor_ram12", ram_mem[12], 8'hEC);
    chk("oor_ram13", ram_mem[13], 8'hED);

    // fill and check, both ports contending throughout
    do_reset();
    gseq.delete();
    for (int a = 0; a < 16; a++) begin
      fill[a] = 8'($urandom);
      v = '{a[0], 1'b1, 4'(a), fill[a], 8'h00};
      load(v);
    end
    for (int a = 0; a < 16; a++) begin
      v = '{a[0], 1'b0, 4'(a), 8'h00, (a < SIZE) ? fill[a] : 8'h00};
      load(v);
    end
    run(400);
    bad = 0;
    for (int i = 0; i < gseq.size(); i++)
      if (gseq[i] != (RR_MODE ? (i % 2) : ((i >= 16) ? 1 : 0))) bad++;
    chk("fill_grants", gseq.size(), 32);
    chk("fill_order", bad, 0);
    chk("fill_ram12", ram_mem[12], 8'hEC);
    chk("fill_ram5", ram_mem[5], fill[5]);

    // reset during RD_DATA
    @(posedge clk); #1;
    bus.req0 = 1; bus.req_we0 = 0; bus.req_addr0 = 4'd3;
    @(negedge clk); chk("mr_gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
    @(posedge clk); #1; bus.req0 = 0;
    @(negedge clk); chk("mr_rdaddr", {bus.cs, bus.we, bus.oe}, 3'b101);
    @(posedge clk); #1;
    rst = 1;
    bus.req0 = 1; bus.req_we0 = 1; bus.req_addr0 = 4'd5; bus.req_wdata0 = 8'h3C;
    bus.req1 = 1; bus.req_we1 = 1; bus.req_addr1 = 4'd6; bus.req_wdata1 = 8'h44;
    @(negedge clk);
    chk("mr_rddata_ctrl", {bus.cs, bus.we, bus.oe}, 3'b101);
    chk("mr_gnt_in_rst", {bus.gnt1, bus.gnt0}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    chk("mr_ctrl", {bus.cs, bus.we, bus.oe}, 0);
    chk("mr_addr", bus.addr, 0);
    chk("mr_rdata", {bus.rdata1, bus.rdata0}, 0);
    chk("mr_gnt_forced", {bus.gnt1, bus.gnt0}, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk); chk("mr_post_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    @(posedge clk); #1; bus.req0 = 0; bus.req1 = 0;
    @(negedge clk); chk("mr_post_wr", {bus.cs, bus.we, bus.oe}, 3'b110);
    @(posedge clk); #1;
    @(negedge clk); chk("mr_post_mem", ram_mem[5], 8'h3C);
    chk("mr_post_rvalid", {bus.rvalid1, bus.rvalid0}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
